mult_div_seq: RTL and testbench

- Iterative signed multiply/divide sequencer owning the HI/LO register pair for the multicycle CPU.
- ctrl_unit pulses start with an operation select, then stalls in a wait state until done.
- Results are read from hi/lo through the MEMtoReg mux (MFHI/MFLO paths).
- Sequences an internal shift-add (Booth radix-2) or shift-subtract (restoring) datapath, one iteration per clock.

---
 rtl/mult_div_seq_if.sv | 37 +++
 rtl/mult_div_seq.sv | 159 +++++++++++++++
 tb/tb_mult_div_seq.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_seq_if.sv
// Handshake and result bundle between ctrl_unit (master) and mult_div_seq (slave).
// MULTDIV_MTHILO_EN adds the MTHI/MTLO write port.
interface mult_div_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       dbg_state;
`ifdef MULTDIV_MTHILO_EN
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
`endif

  // start is a single-cycle request accepted only while idle; done is a
  // one-cycle pulse and hi/lo/div_zero are valid from that cycle onwards.
  modport master (
    output start, op, a, b,
`ifdef MULTDIV_MTHILO_EN
    output wr_hi, wr_lo, wr_data,
`endif
    input  busy, done, div_zero, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, a, b,
`ifdef MULTDIV_MTHILO_EN
    input  wr_hi, wr_lo, wr_data,
`endif
    output busy, done, div_zero, hi, lo, dbg_state
  );
endinterface

// File: rtl/mult_div_seq.sv
// Iterative signed MULT (Booth radix-2) / DIV (restoring) unit owning HI/LO.
// Optional MTHI/MTLO write port enabled by MULTDIV_MTHILO_EN.
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input logic            clock,
  input logic            reset,
  mult_div_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic             op_r;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] qr;
  logic             q_1;
  logic [WIDTH:0]   m;
  logic             neg_q;
  logic             neg_r;
  logic             busy_r;
  logic             done_r;
  logic             dz_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic             wr_hi_en;
  logic             wr_lo_en;
  logic [WIDTH-1:0] wr_val;

`ifdef MULTDIV_MTHILO_EN
  assign wr_hi_en = bus.wr_hi;
  assign wr_lo_en = bus.wr_lo;
  assign wr_val   = bus.wr_data;
`else
  assign wr_hi_en = 1'b0;
  assign wr_lo_en = 1'b0;
  assign wr_val   = '0;
`endif

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             b_zero;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] qr_nxt;
  logic             q1_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    mag_a   = bus.a[WIDTH-1] ? -bus.a : bus.a;
    mag_b   = bus.b[WIDTH-1] ? -bus.b : bus.b;
    b_zero  = (bus.b == '0);
    sum     = acc;
    shifted = '0;
    trial   = '0;
    acc_nxt = acc;
    qr_nxt  = qr;
    q1_nxt  = q_1;
    if (!op_r) begin
      // Booth step on {acc, qr, q_1}; acc carries one guard bit so that
      // subtracting the most negative multiplicand cannot overflow.
      case ({qr[0], q_1})
        2'b01:   sum = acc + m;
        2'b10:   sum = acc - m;
        default: sum = acc;
      endcase
      {acc_nxt, qr_nxt, q1_nxt} = {sum[WIDTH], sum, qr};
    end else begin
      shifted = {acc[WIDTH-1:0], qr[WIDTH-1]};
      trial   = shifted - m;
      if (!trial[WIDTH]) begin
        acc_nxt = trial;
        qr_nxt  = {qr[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted;
        qr_nxt  = {qr[WIDTH-2:0], 1'b0};
      end
    end
    q_fix = neg_q ? -qr : qr;
    r_fix = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      count  <= '0;
      op_r   <= 1'b0;
      acc    <= '0;
      qr     <= '0;
      q_1    <= 1'b0;
      m      <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_r   <= bus.op;
            busy_r <= 1'b1;
            count  <= '0;
            dz_r   <= bus.op && b_zero;
            acc    <= '0;
            q_1    <= 1'b0;
            qr     <= bus.op ? mag_a : bus.b;
            m      <= bus.op ? {1'b0, mag_b} : {bus.a[WIDTH-1], bus.a};
            neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            neg_r  <= bus.a[WIDTH-1];
            state  <= (bus.op && b_zero) ? S_FINISH : S_RUN;
          end else begin
            if (wr_hi_en) hi_r <= wr_val;
            if (wr_lo_en) lo_r <= wr_val;
          end
        end
        S_RUN: begin
          acc   <= acc_nxt;
          qr    <= qr_nxt;
          q_1   <= q1_nxt;
          count <= count + 1'b1;
          if (count == LAST) state <= S_FINISH;
        end
        S_FINISH: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          // A divide-by-zero leaves HI/LO holding their previous contents.
          if (!dz_r) begin
            hi_r <= op_r ? r_fix : acc[WIDTH-1:0];
            lo_r <= op_r ? q_fix : qr;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.div_zero  = dz_r;
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: vector table, random ops against a
// reference model, and hand-written multi-cycle corner sequences.
module tb_mult_div_seq;

  localparam int W = 32;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  mult_div_seq_if #(.WIDTH(W)) bus ();

  mult_div_seq #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t           tbl [9];
  logic [2*W:0]   exp_q [$];
  logic [2*W-1:0] model_hilo;
  int             errors = 0;
  int             checks = 0;
  int             done_count = 0;
  string          cur_name = "init";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W:0] model(input logic op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [2*W-1:0] prev);
    logic signed [2*W-1:0] sa, sb, p, q, r;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    if (!op) begin
      p = sa * sb;
      return {1'b0, p};
    end
    if (b == '0) return {1'b1, prev};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction

  // Scoreboard: every done pulse retires the oldest expected result.
  always @(negedge clock) begin
    if (!reset && bus.done) begin
      logic [2*W:0] e;
      done_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done (%s): got done=1 expected no done", cur_name);
      end else begin
        e = exp_q.pop_front();
        check({cur_name, "_hilo"}, {bus.hi, bus.lo}, e[2*W-1:0]);
        check({cur_name, "_div_zero"}, 64'(bus.div_zero), 64'(e[2*W]));
      end
    end
  end

  task automatic pulse_start(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W:0] e);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    exp_q.push_back(e);
    model_hilo = e[2*W-1:0];
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.op    = 1'($urandom_range(0, 1));
    bus.a     = $urandom;
    bus.b     = $urandom;
    check({cur_name, "_busy_after_start"}, 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_done(input int exp_lat);
    int lat;
    lat = 0;
    while (!bus.done && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check({cur_name, "_latency"}, 64'(lat), 64'(exp_lat));
    if (bus.done) check({cur_name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic done_low_next();
    @(posedge clock);
    #1;
    check({cur_name, "_done_one_cycle"}, 64'(bus.done), 64'd0);
  endtask

  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W:0] e);
    pulse_start(op, a, b, e);
    wait_done(e[2*W] ? 1 : W + 1);
    done_low_next();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2*W:0]   e;
    logic [W-1:0]   ra, rb;
    logic           rop;
    int             snap;
    logic [W-1:0]   old_lo;

    tbl[0] = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000};
    tbl[2] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0001};
    tbl[3] = '{1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'hC000_0000, 32'h8000_0000};
    tbl[4] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[5] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[6] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_0005, 32'h0000_0000};
    tbl[7] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000};
    tbl[8] = '{1'b1, 32'h0000_0064, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h8000_0000};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef MULTDIV_MTHILO_EN
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
    bus.wr_data = '0;
`endif
    model_hilo = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    cur_name = "reset";
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_div_zero", 64'(bus.div_zero), 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_state", 64'(bus.dbg_state), 64'd0);
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < 9; i++) begin
      cur_name = $sformatf("vec%0d", i);
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].dz, tbl[i].hi, tbl[i].lo});
    end

    // div_zero holds while idle and clears on the next accepted start
    cur_name = "dz_hold";
    repeat (3) @(posedge clock);
    #1;
    check("dz_hold_flag", 64'(bus.div_zero), 64'd1);
    check("dz_hold_hilo", {bus.hi, bus.lo}, {32'h0, 32'h8000_0000});

    // Random operations against the reference model
    for (int i = 0; i < 8; i++) begin
      cur_name = $sformatf("rand%0d", i);
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = (i % 3 == 1) ? W'($urandom_range(1, 100)) : W'($urandom);
      if (i == 0) rb = rb | 32'h1;
      if (i == 5) rb = '0;
      e = model(rop, ra, rb, model_hilo);
      pulse_start(rop, ra, rb, e);
      if (i == 0) check("dz_cleared_on_start", 64'(bus.div_zero), 64'd0);
      wait_done(e[2*W] ? 1 : W + 1);
      done_low_next();
    end

    // start in the same cycle as done is accepted
    cur_name = "b2b_first";
    pulse_start(1'b0, 32'd6, 32'd7, {1'b0, 32'd0, 32'd42});
    wait_done(W + 1);
    cur_name = "b2b_second";
    pulse_start(1'b1, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14});
    wait_done(W + 1);
    done_low_next();

    // second start while busy is ignored
    cur_name = "ignored_start";
    snap = done_count;
    pulse_start(1'b0, 32'h0001_0000, 32'h0001_0000, {1'b0, 32'h1, 32'h0});
    repeat (4) @(posedge clock);
    #1;
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd5;
    bus.b     = 32'd0;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    wait_done(W + 1 - 5);
    repeat (40) @(posedge clock);
    #1;
    check("ignored_start_done_count", 64'(done_count - snap), 64'd1);
    check("ignored_start_dz", 64'(bus.div_zero), 64'd0);

    // reset in the middle of a MULT
    cur_name = "mid_reset";
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'h1234;
    bus.b     = 32'h5678;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("mid_reset_busy", 64'(bus.busy), 64'd0);
    check("mid_reset_done", 64'(bus.done), 64'd0);
    check("mid_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("mid_reset_state", 64'(bus.dbg_state), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_hilo = '0;
    snap = done_count;
    repeat (40) @(posedge clock);
    #1;
    check("mid_reset_no_done", 64'(done_count - snap), 64'd0);
    check("mid_reset_hilo_hold", {bus.hi, bus.lo}, 64'd0);
    cur_name = "after_reset";
    run_op(1'b0, 32'd3, 32'd4, {1'b0, 32'd0, 32'd12});

`ifdef MULTDIV_MTHILO_EN
    // MTHI in idle, then writes dropped with start and while busy
    cur_name = "mthi";
    bus.wr_hi   = 1'b1;
    bus.wr_data = 32'hDEAD_BEEF;
    @(posedge clock);
    #1;
    bus.wr_hi = 1'b0;
    check("mthi_hi", 64'(bus.hi), 64'hDEAD_BEEF);
    check("mthi_lo_kept", 64'(bus.lo), 64'(model_hilo[W-1:0]));
    model_hilo[2*W-1:W] = 32'hDEAD_BEEF;
    old_lo = model_hilo[W-1:0];
    cur_name = "mtlo_dropped";
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'h1111_1111;
    pulse_start(1'b0, 32'd2, 32'd5, {1'b0, 32'd0, 32'd10});
    bus.wr_data = 32'h2222_2222;
    repeat (3) @(posedge clock);
    #1;
    check("mtlo_busy_lo", 64'(bus.lo), 64'(old_lo));
    check("mtlo_busy_hi", 64'(bus.hi), 64'hDEAD_BEEF);
    bus.wr_lo = 1'b0;
    wait_done(W + 1 - 3);
    done_low_next();
`else
    old_lo = '0;
`endif

    repeat (5) @(posedge clock);
    #1;
    cur_name = "final";
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_busy", 64'(bus.busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
